// File: rtl/eca_bm_pkg.sv
// Shared types and default sizes for the ECA bitmatrix memory controller.
// Optional build macro: ECA_BM_PARITY_EN (per-word even parity on the banks).
package eca_bm_pkg;

  typedef enum logic [1:0] {
    BM_EMPTY,
    BM_LOADING,
    BM_READY,
    BM_ACTIVE
  } bm_set_state_e;

  localparam int BM_MEM_W_DEF     = 32;
  localparam int BM_MEM_DEPTH_DEF = 64;
  localparam int NUM_SETS_DEF     = 2;

  // Set index width, never narrower than one bit.
  function automatic int set_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eca_bm_set_fsm.sv
// Lifecycle FSM of one bitmatrix set: EMPTY/LOADING/READY/ACTIVE.
// ready_o is high while the set holds a committed bitmatrix.
module eca_bm_set_fsm
  import eca_bm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic          commit_i,
  input  logic          inval_i,
  input  logic          act_i,
  input  logic          rel_i,
  output bm_set_state_e state_o,
  output logic          ready_o
);

  bm_set_state_e state_q;
  logic          ready_q;

  // Lifecycle transitions; inval beats commit, ACTIVE ignores user events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BM_EMPTY;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        BM_ACTIVE: begin
          if (!act_i && rel_i) begin
            state_q <= BM_READY;
          end
        end
        BM_READY: begin
          if (inval_i) begin
            state_q <= BM_EMPTY;
            ready_q <= 1'b0;
          end else if (act_i) begin
            state_q <= BM_ACTIVE;
          end
        end
        BM_LOADING: begin
          if (inval_i) begin
            state_q <= BM_EMPTY;
          end else if (commit_i) begin
            state_q <= BM_READY;
            ready_q <= 1'b1;
          end
        end
        default: begin
          if (inval_i) begin
            state_q <= BM_EMPTY;
          end else if (commit_i) begin
            state_q <= BM_READY;
            ready_q <= 1'b1;
          end else if (wr_i) begin
            state_q <= BM_LOADING;
          end
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/eca_bm_mem_ctrl.sv
// Multi-set bitmatrix memory: user loads idle sets, control reads the active one.
// Build macro ECA_BM_PARITY_EN adds an even-parity bit per stored word.
module eca_bm_mem_ctrl
  import eca_bm_pkg::*;
#(
  parameter int BM_MEM_W     = BM_MEM_W_DEF,
  parameter int BM_MEM_DEPTH = BM_MEM_DEPTH_DEF,
  parameter int NUM_SETS     = NUM_SETS_DEF,
  parameter int ADDR_W       = $clog2(BM_MEM_DEPTH),
  parameter int SET_W        = set_w(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                user_wr_req,
  input  logic [SET_W-1:0]    user_wr_set,
  input  logic [ADDR_W-1:0]   user_wr_addr,
  input  logic [BM_MEM_W-1:0] user_wr_data,
  output logic                user_wr_ack,
  output logic                user_wr_err,
  input  logic                user_commit,
  input  logic                user_inval,
  input  logic                cntl_job_start,
  input  logic                cntl_job_done,
  output logic                cntl_start_err,
  input  logic                cntl_rd_req,
  input  logic [ADDR_W-1:0]   cntl_rd_addr,
  output logic [BM_MEM_W-1:0] cntl_rd_data,
  output logic                cntl_rd_data_val,
  output logic                cntl_rd_err,
  output logic                active_val,
  output logic [SET_W-1:0]    active_set,
  output logic [NUM_SETS-1:0] set_ready,
  output logic                rd_parity_err
);

`ifdef ECA_BM_PARITY_EN
  localparam int WORD_W = BM_MEM_W + 1;
`else
  localparam int WORD_W = BM_MEM_W;
`endif

  bm_set_state_e st [NUM_SETS];

  logic [NUM_SETS-1:0] wr_hit;
  logic [NUM_SETS-1:0] commit_hit;
  logic [NUM_SETS-1:0] inval_hit;
  logic [NUM_SETS-1:0] act;
  logic [NUM_SETS-1:0] rel;
  logic [NUM_SETS-1:0] elig;

  logic              set_hit;
  logic              wr_blk;
  logic              wr_ok;
  logic              done_eff;
  logic              found;
  logic [SET_W-1:0]  sel;
  logic              start_ok;
  logic              rd_ok;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] rd_word;
  logic              rd_bad;

  logic [WORD_W-1:0]   bank_q [NUM_SETS][BM_MEM_DEPTH];
  logic                active_val_q;
  logic [SET_W-1:0]    active_set_q;
  logic [SET_W-1:0]    ptr_q;
  logic                start_err_q;
  logic                wr_ack_q;
  logic                wr_err_q;
  logic                rd_val_q;
  logic                rd_err_q;
  logic [BM_MEM_W-1:0] rd_data_q;
  logic                par_err_q;

  assign done_eff = cntl_job_done && active_val_q;

  // Decode user/control events per set and build the eligibility mask.
  always_comb begin
    set_hit = 1'b0;
    wr_blk  = 1'b0;
    for (int i = 0; i < NUM_SETS; i++) begin
      if (user_wr_set == SET_W'(i)) begin
        set_hit = 1'b1;
        if (st[i] == BM_ACTIVE) wr_blk = 1'b1;
      end
    end
    wr_ok = user_wr_req && set_hit && !wr_blk;
    for (int i = 0; i < NUM_SETS; i++) begin
      wr_hit[i]     = wr_ok && (user_wr_set == SET_W'(i));
      commit_hit[i] = user_commit && (user_wr_set == SET_W'(i));
      inval_hit[i]  = user_inval && (user_wr_set == SET_W'(i));
      rel[i]        = done_eff && (active_set_q == SET_W'(i));
      elig[i]       = ((st[i] == BM_READY) && !inval_hit[i]) || rel[i];
    end
  end

  // Round-robin scan from the set after the last one activated.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_SETS; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_SETS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = SET_W'(idx);
      end
    end
    start_ok = cntl_job_start && (!active_val_q || cntl_job_done) && found;
    for (int i = 0; i < NUM_SETS; i++) begin
      act[i] = start_ok && (sel == SET_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_SETS; g++) begin : g_set
    eca_bm_set_fsm u_fsm (
      .clk      (clk),
      .rst      (rst),
      .wr_i     (wr_hit[g]),
      .commit_i (commit_hit[g]),
      .inval_i  (inval_hit[g]),
      .act_i    (act[g]),
      .rel_i    (rel[g]),
      .state_o  (st[g]),
      .ready_o  (set_ready[g])
    );
  end

`ifdef ECA_BM_PARITY_EN
  assign wr_word = {^user_wr_data, user_wr_data};
  assign rd_bad  = ^rd_word;
`else
  assign wr_word = user_wr_data;
  assign rd_bad  = 1'b0;
`endif

  assign rd_ok   = cntl_rd_req && active_val_q;
  assign rd_word = bank_q[active_set_q][cntl_rd_addr];

  // Bank storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      bank_q[user_wr_set][user_wr_addr] <= wr_word;
    end
  end

  // Active-set tracking and registered status/read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_val_q <= 1'b0;
      active_set_q <= '0;
      ptr_q        <= '0;
      start_err_q  <= 1'b0;
      wr_ack_q     <= 1'b0;
      wr_err_q     <= 1'b0;
      rd_val_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_data_q    <= '0;
      par_err_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        active_val_q <= 1'b1;
        active_set_q <= sel;
        ptr_q        <= (int'(sel) == NUM_SETS - 1) ? '0 : sel + 1'b1;
      end else if (done_eff) begin
        active_val_q <= 1'b0;
      end
      start_err_q <= cntl_job_start && !start_ok;
      wr_ack_q    <= wr_ok;
      wr_err_q    <= user_wr_req && !wr_ok;
      rd_val_q    <= rd_ok;
      rd_err_q    <= cntl_rd_req && !active_val_q;
      par_err_q   <= rd_ok && rd_bad;
      if (rd_ok) begin
        rd_data_q <= rd_word[BM_MEM_W-1:0];
      end
    end
  end

  assign user_wr_ack      = wr_ack_q;
  assign user_wr_err      = wr_err_q;
  assign cntl_start_err   = start_err_q;
  assign cntl_rd_data     = rd_data_q;
  assign cntl_rd_data_val = rd_val_q;
  assign cntl_rd_err      = rd_err_q;
  assign active_val       = active_val_q;
  assign active_set       = active_set_q;
  assign rd_parity_err    = par_err_q;

endmodule

// File: tb/tb_eca_bm_mem_ctrl.sv
// Directed bench for eca_bm_mem_ctrl with hand-computed expectations.
// Parity section follows ECA_BM_PARITY_EN.
module tb_eca_bm_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        user_wr_req;
  logic [0:0]  user_wr_set;
  logic [5:0]  user_wr_addr;
  logic [31:0] user_wr_data;
  logic        user_wr_ack;
  logic        user_wr_err;
  logic        user_commit;
  logic        user_inval;
  logic        cntl_job_start;
  logic        cntl_job_done;
  logic        cntl_start_err;
  logic        cntl_rd_req;
  logic [5:0]  cntl_rd_addr;
  logic [31:0] cntl_rd_data;
  logic        cntl_rd_data_val;
  logic        cntl_rd_err;
  logic        active_val;
  logic [0:0]  active_set;
  logic [1:0]  set_ready;
  logic        rd_parity_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  eca_bm_mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .user_wr_req      (user_wr_req),
    .user_wr_set      (user_wr_set),
    .user_wr_addr     (user_wr_addr),
    .user_wr_data     (user_wr_data),
    .user_wr_ack      (user_wr_ack),
    .user_wr_err      (user_wr_err),
    .user_commit      (user_commit),
    .user_inval       (user_inval),
    .cntl_job_start   (cntl_job_start),
    .cntl_job_done    (cntl_job_done),
    .cntl_start_err   (cntl_start_err),
    .cntl_rd_req      (cntl_rd_req),
    .cntl_rd_addr     (cntl_rd_addr),
    .cntl_rd_data     (cntl_rd_data),
    .cntl_rd_data_val (cntl_rd_data_val),
    .cntl_rd_err      (cntl_rd_err),
    .active_val       (active_val),
    .active_set       (active_set),
    .set_ready        (set_ready),
    .rd_parity_err    (rd_parity_err)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    user_wr_req    = 1'b0;
    user_wr_set    = '0;
    user_wr_addr   = '0;
    user_wr_data   = '0;
    user_commit    = 1'b0;
    user_inval     = 1'b0;
    cntl_job_start = 1'b0;
    cntl_job_done  = 1'b0;
    cntl_rd_req    = 1'b0;
    cntl_rd_addr   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input logic s, input logic [5:0] a, input logic [31:0] d);
    user_wr_req  = 1'b1;
    user_wr_set  = s;
    user_wr_addr = a;
    user_wr_data = d;
    step();
  endtask

  task automatic commit(input logic s);
    user_commit = 1'b1;
    user_wr_set = s;
    step();
  endtask

  task automatic rd(input logic [5:0] a);
    cntl_rd_req  = 1'b1;
    cntl_rd_addr = a;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_ready", set_ready, 2'b00);
    check("rst_aval", active_val, 1'b0);
    check("rst_aset", active_set, 1'b0);
    check("rst_val", cntl_rd_data_val, 1'b0);
    check("rst_data", cntl_rd_data, 32'h0);
    check("rst_flags", {user_wr_ack, user_wr_err, cntl_start_err,
                        cntl_rd_err, rd_parity_err}, 5'b0);
    rst = 1'b0;

    // No READY set: start and read both error.
    cntl_job_start = 1'b1;
    step();
    check("empty_start_err", cntl_start_err, 1'b1);
    check("empty_aval", active_val, 1'b0);
    rd(6'd0);
    check("empty_rd_err", cntl_rd_err, 1'b1);
    check("empty_rd_val", cntl_rd_data_val, 1'b0);
    check("start_err_pulse", cntl_start_err, 1'b0);

    // Load set0, commit, activate, read with one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, 6'(i), 32'hA0 + 32'(i));
      check("ld0_ack", {user_wr_ack, user_wr_err}, 2'b10);
    end
    check("ld0_loading", set_ready, 2'b00);
    commit(1'b0);
    check("commit0", set_ready, 2'b01);
    cntl_job_start = 1'b1;
    step();
    check("start0", {active_val, active_set, cntl_start_err}, 3'b100);
    rd(6'd2);
    check("rd2_val", cntl_rd_data_val, 1'b1);
    check("rd2_data", cntl_rd_data, 32'hA2);
    check("rd2_par", rd_parity_err, 1'b0);
    step();
    check("rd_val_drop", cntl_rd_data_val, 1'b0);
    check("rd_hold", cntl_rd_data, 32'hA2);

    // Writes into the active set are rejected.
    wr(1'b0, 6'd1, 32'h55);
    check("wr_active", {user_wr_ack, user_wr_err}, 2'b01);
    rd(6'd1);
    check("rd1_old", cntl_rd_data, 32'hA1);

    // Load set1 then swap with done+start in one cycle.
    wr(1'b1, 6'd0, 32'hB0);
    check("ld1_ack", user_wr_ack, 1'b1);
    wr(1'b1, 6'd1, 32'hB1);
    commit(1'b1);
    check("both_ready", set_ready, 2'b11);
    cntl_job_done  = 1'b1;
    cntl_job_start = 1'b1;
    step();
    check("swap_set", {active_val, active_set}, 2'b11);
    check("swap_ready", set_ready, 2'b11);
    check("swap_err", cntl_start_err, 1'b0);
    rd(6'd0);
    check("rd_b0", cntl_rd_data, 32'hB0);

    // Start while a job runs is an error; active set kept.
    cntl_job_start = 1'b1;
    step();
    check("busy_start_err", cntl_start_err, 1'b1);
    check("busy_set", {active_val, active_set}, 2'b11);

    // Round-robin returns to set0.
    cntl_job_done  = 1'b1;
    cntl_job_start = 1'b1;
    step();
    check("rr_set0", {active_val, active_set}, 2'b10);

    // Write and commit together on READY set1: accepted, stays READY.
    user_wr_req  = 1'b1;
    user_wr_set  = 1'b1;
    user_wr_addr = 6'd5;
    user_wr_data = 32'hC5;
    user_commit  = 1'b1;
    step();
    check("wrc_ack", user_wr_ack, 1'b1);
    check("wrc_ready", set_ready, 2'b11);

    // Commit and inval together: inval wins.
    user_commit = 1'b1;
    user_inval  = 1'b1;
    user_wr_set = 1'b1;
    step();
    check("inval_wins", set_ready, 2'b01);

    // Inval on the active set is ignored.
    user_inval  = 1'b1;
    user_wr_set = 1'b0;
    step();
    check("inval_active", {active_val, set_ready}, 3'b101);

    // Asynchronous reset during a read.
    rd(6'd3);
    check("rd3_data", {cntl_rd_data_val, cntl_rd_data}, {1'b1, 32'hA3});
    #2;
    rst = 1'b1;
    #1;
    check("arst_val", cntl_rd_data_val, 1'b0);
    check("arst_state", {active_val, set_ready}, 3'b000);
    check("arst_data", cntl_rd_data, 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold", {cntl_rd_data_val, active_val, set_ready}, 4'b0);
    rst = 1'b0;

    // Parity error detection on a corrupted word.
    wr(1'b0, 6'd2, 32'h0F);
    commit(1'b0);
    cntl_job_start = 1'b1;
    step();
`ifdef ECA_BM_PARITY_EN
    dut.bank_q[0][2][0] = ~dut.bank_q[0][2][0];
    rd(6'd2);
    check("par_val", cntl_rd_data_val, 1'b1);
    check("par_data", cntl_rd_data, 32'h0E);
    check("par_err", rd_parity_err, 1'b1);
`else
    rd(6'd2);
    check("nopar_data", {cntl_rd_data_val, cntl_rd_data}, {1'b1, 32'h0F});
    check("nopar_err", rd_parity_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eca_bm_mem_ctrl.md
Name: eca_bm_mem_ctrl

Overview:
Multi-set bitmatrix memory controller for the ECA; successor of the single-bank bitmatrix SRAM plus address mux.
- Holds NUM_SETS independent bitmatrix banks, each with a per-set lifecycle FSM.
- The user loads or reloads inactive sets while control streams columns from the active set.
- Sits between the user bitmatrix interface, control_top and regs_top.

Parameters:
BM_MEM_W, 32, bitmatrix word width
BM_MEM_DEPTH, 64, words per set
NUM_SETS, 2, number of bitmatrix sets (>=2)
ADDR_W, $clog2(BM_MEM_DEPTH), word address width
SET_W, $clog2(NUM_SETS) (min 1), set index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
user_wr_req  in  1  write request
user_wr_set  in  SET_W  target set
user_wr_addr  in  ADDR_W  word address
user_wr_data  in  BM_MEM_W  write data
user_wr_ack  out  1  write accepted (registered, +1 cycle)
user_wr_err  out  1  write rejected (registered, +1 cycle)
user_commit  in  1  mark user_wr_set READY
user_inval  in  1  mark user_wr_set EMPTY
cntl_job_start  in  1  select next READY set as active
cntl_job_done  in  1  release active set
cntl_start_err  out  1  job_start with no READY set
cntl_rd_req  in  1  read from active set
cntl_rd_addr  in  ADDR_W  read address
cntl_rd_data  out  BM_MEM_W  read data
cntl_rd_data_val  out  1  read data valid
cntl_rd_err  out  1  read with no active set
active_val  out  1  an active set exists
active_set  out  SET_W  active set index
set_ready  out  NUM_SETS  per-set READY or ACTIVE flag
rd_parity_err  out  1  parity error (see optional feature)

Behaviour:
- Reset: all sets EMPTY; every output 0. Memory contents are undefined and not cleared.
- Per-set FSM states and transitions:
  - EMPTY -> LOADING on an accepted write.
  - EMPTY or LOADING -> READY on user_commit.
  - READY -> ACTIVE when selected by cntl_job_start.
  - ACTIVE -> READY on cntl_job_done; the bitmatrix is kept for reuse.
  - READY or LOADING -> EMPTY on user_inval.
  - user_inval on an ACTIVE set is ignored.
- Writes:
  - Accepted if the target set is not ACTIVE and user_wr_set < NUM_SETS.
  - Otherwise the memory is unchanged and user_wr_err pulses at t+1.
  - A write to a READY set is accepted and the set stays READY.
- Banks are separate, one per set. Reads always target the active set and writes never do, so there is no read/write contention.
- Read latency is 1 cycle:
  - cntl_rd_req at t gives cntl_rd_data and cntl_rd_data_val at t+1.
  - cntl_rd_data holds its last value when val is low.
  - With no active set, cntl_rd_err pulses at t+1 and val stays 0.
- Job start selection:
  - Round-robin: first READY set scanning from (last active + 1) mod NUM_SETS. After reset the scan starts at set 0.
  - active_set and active_val update at t+1.
  - With no READY set: cntl_start_err pulses at t+1 and state is unchanged.
  - cntl_job_start while a set is ACTIVE without job_done in the same cycle is treated as an error: cntl_start_err pulses and the active set is unchanged.
- Simultaneous events:
  - job_done and job_start in the same cycle: done is applied first, then selection. The released set is eligible but is scanned last.
  - Write and commit to the same set in the same cycle: the write is applied and the set ends READY.
  - Commit and inval in the same cycle: inval wins.
  - Commit or write to an ACTIVE set: ignored, and user_wr_err pulses for the write.
- Reset mid-operation: every FSM returns to EMPTY immediately, any in-flight read valid is dropped and all outputs are 0.

Optional Feature:
ECA_BM_PARITY_EN
- Defined: each word stores an even-parity bit alongside the data. On every read, the parity check result is registered with the data. rd_parity_err pulses with cntl_rd_data_val on a mismatch, and the data is still delivered.
- Undefined: no parity storage; rd_parity_err is tied to 0.

Decomposition:
- Package eca_bm_pkg holds:
  - typedef enum logic [1:0] bm_set_state_e {BM_EMPTY, BM_LOADING, BM_READY, BM_ACTIVE};
  - default width constants.
- Natural sub-module: eca_bm_set_fsm, one instance per set, holding the lifecycle FSM and ready flag.
- The round-robin selector and the banks stay in the parent.

Test Plan:
1. Write set0 addr0..3 = 0xA0..0xA3, commit, job_start, read addr2 -> rd_data 0xA2 with val exactly 1 cycle after req; active_set=0.
2. Set0 ACTIVE; write set0 addr1 -> user_wr_err at t+1 and no ack; read addr1 returns the old value.
3. Set0 ACTIVE; load and commit set1; job_done and job_start in the same cycle -> active_set=1 at t+1, set_ready=2'b11.
4. All sets EMPTY; job_start -> cntl_start_err pulse; rd_req -> cntl_rd_err at t+1, val=0.
5. Set0 ACTIVE; user_inval on set0 -> ignored; rst asserted mid-read -> val=0, active_val=0, set_ready=0.
6. With ECA_BM_PARITY_EN: force-flip a stored bit via backdoor, read it -> rd_parity_err=1 with val; without the macro, rd_parity_err stays 0.
